// File: rtl/interval_sequencer.sv
// interval_sequencer: requester side of the timer start/done level handshake.
// Runs a programmable number of back-to-back timed intervals, re-arms the
// timer between intervals (keeping start_clock low until the previous done
// level has cleared), and flags a timer that never answers.
module interval_sequencer #(
  parameter int STEP_W   = 4,
  parameter int GAP_CYC  = 2,
  parameter int WD_W     = 28,
  parameter int WD_LIMIT = 250000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  input  logic [STEP_W-1:0] steps,
  input  logic              pause,
  input  logic              abort,
  input  logic              clock_done,
  output logic              start_clock,
  output logic              step_tick,
  output logic [STEP_W-1:0] step_index,
  output logic              busy,
  output logic              seq_done,
  output logic              timeout_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam int                GAP_W   = (GAP_CYC < 1) ? 1 : $clog2(GAP_CYC + 1);
  localparam logic [GAP_W-1:0]  GAP_LIM = GAP_W'(GAP_CYC);
  localparam logic [WD_W-1:0]   WD_LIM  = WD_W'(WD_LIMIT);
  localparam logic [WD_W-1:0]   WD_MAX  = {WD_W{1'b1}};

  state_t              state_r, state_s;
  logic [STEP_W-1:0]   steps_r;
  logic [STEP_W-1:0]   step_index_r;
  logic [WD_W-1:0]     wd_r;
  logic [GAP_W-1:0]    gap_r;
  logic                first_r;
  logic                start_clock_r, step_tick_r, busy_r, seq_done_r, timeout_err_r;

  logic                accept_s, advance_s, tick_s, done_s, timeout_s;
  logic                last_s, wd_expire_s, gap_ok_s;
  logic [WD_W-1:0]     wd_inc_s;

  // Interval bookkeeping helpers: last interval, saturating watchdog, gap elapsed.
  always_comb begin
    last_s      = (step_index_r == (steps_r - {{(STEP_W-1){1'b0}}, 1'b1}));
    wd_inc_s    = (wd_r == WD_MAX) ? wd_r : (wd_r + {{(WD_W-1){1'b0}}, 1'b1});
    wd_expire_s = (wd_inc_s >= WD_LIM);
    gap_ok_s    = (gap_r >= GAP_LIM);
  end

  // Next-state and event decode; abort outranks done and watchdog expiry.
  always_comb begin
    state_s   = state_r;
    accept_s  = 1'b0;
    advance_s = 1'b0;
    tick_s    = 1'b0;
    done_s    = 1'b0;
    timeout_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (go) begin
          if (steps == {STEP_W{1'b0}}) begin
            done_s  = 1'b1;
            state_s = IDLE;
          end else begin
            accept_s = 1'b1;
            // A done level left over from an earlier interval must clear first.
            if (clock_done) begin
              state_s = GAP;
            end else begin
              state_s = RUN;
            end
          end
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (abort) begin
          state_s = IDLE;
        end else if (clock_done) begin
          tick_s = 1'b1;
          if (last_s) begin
            done_s  = 1'b1;
            state_s = IDLE;
          end else begin
            state_s = GAP;
          end
        end else if (wd_expire_s) begin
          timeout_s = 1'b1;
          state_s   = IDLE;
        end else begin
          state_s = RUN;
        end
      end
      GAP: begin
        if (abort) begin
          state_s = IDLE;
        end else if (gap_ok_s && !clock_done && !pause) begin
          advance_s = 1'b1;
          state_s   = RUN;
        end else begin
          state_s = GAP;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Registered handshake and status outputs, derived from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      start_clock_r <= 1'b0;
      busy_r        <= 1'b0;
      step_tick_r   <= 1'b0;
      seq_done_r    <= 1'b0;
    end else begin
      start_clock_r <= (state_s == RUN);
      busy_r        <= (state_s != IDLE);
      step_tick_r   <= tick_s;
      seq_done_r    <= done_s;
    end
  end

  // Latched step count, interval index and first-interval marker.
  always_ff @(posedge clk) begin
    if (rst) begin
      steps_r      <= {STEP_W{1'b0}};
      step_index_r <= {STEP_W{1'b0}};
      first_r      <= 1'b0;
    end else if (accept_s) begin
      steps_r      <= steps;
      step_index_r <= {STEP_W{1'b0}};
      // Only a sequence that starts in GAP has no completed interval to step past.
      first_r      <= clock_done;
    end else if (advance_s) begin
      if (!first_r) begin
        step_index_r <= step_index_r + {{(STEP_W-1){1'b0}}, 1'b1};
      end
      first_r <= 1'b0;
    end
  end

  // Watchdog: cleared at the start of each interval, saturating count in RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_r <= {WD_W{1'b0}};
    end else if (accept_s || advance_s) begin
      wd_r <= {WD_W{1'b0}};
    end else if (state_r == RUN) begin
      wd_r <= wd_inc_s;
    end
  end

  // Gap counter: restarts on GAP entry, saturates once the minimum gap is met.
  always_ff @(posedge clk) begin
    if (rst) begin
      gap_r <= {GAP_W{1'b0}};
    end else if ((state_s == GAP) && (state_r != GAP)) begin
      gap_r <= {GAP_W{1'b0}};
    end else if ((state_r == GAP) && !gap_ok_s) begin
      gap_r <= gap_r + {{(GAP_W-1){1'b0}}, 1'b1};
    end
  end

  // Sticky timeout flag, cleared by reset or any go accepted in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      timeout_err_r <= 1'b0;
    end else if ((state_r == IDLE) && go) begin
      timeout_err_r <= 1'b0;
    end else if (timeout_s) begin
      timeout_err_r <= 1'b1;
    end
  end

  assign start_clock = start_clock_r;
  assign step_tick   = step_tick_r;
  assign step_index  = step_index_r;
  assign busy        = busy_r;
  assign seq_done    = seq_done_r;
  assign timeout_err = timeout_err_r;

endmodule

// File: tb/tb_interval_sequencer.sv
// Testbench for interval_sequencer: directed steps from the test plan plus
// randomized sequences, checked against an event-level reference model.
module tb_interval_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       go = 1'b0;
  logic [3:0] steps = 4'd0;
  logic       pause = 1'b0;
  logic       abort = 1'b0;
  logic       clock_done = 1'b0;
  logic       start_clock, step_tick, busy, seq_done, timeout_err;
  logic [3:0] step_index;
  logic       tmr_en = 1'b1;
  int         tcnt = 0;

  int checks = 0;
  int failures = 0;

  interval_sequencer #(.STEP_W(4), .GAP_CYC(2), .WD_W(28), .WD_LIMIT(20)) dut (
    .clk(clk), .rst(rst), .go(go), .steps(steps), .pause(pause), .abort(abort),
    .clock_done(clock_done), .start_clock(start_clock), .step_tick(step_tick),
    .step_index(step_index), .busy(busy), .seq_done(seq_done), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Timer model: done 5 cycles after start_clock rises, clear 1 cycle after it falls.
  always @(posedge clk) begin
    if (!tmr_en || !start_clock) begin
      tcnt       <= 0;
      clock_done <= 1'b0;
    end else begin
      if (tcnt < 5) tcnt <= tcnt + 1;
      if (tcnt == 4) clock_done <= 1'b1;
    end
  end

  // Event monitor (mid-cycle): logs ticks, done pulses and start_clock run lengths.
  int q_tick[$];
  int q_gap[$];
  int q_high[$];
  int n_done = 0, n_done_tick = 0, n_done_idle = 0, n_viol = 0, n_busy = 0;
  int low_len = 0, high_len = 0;
  logic prev_sc = 1'b0, prev_busy = 1'b0;

  always @(negedge clk) begin
    if (step_tick === 1'b1) q_tick.push_back(int'(step_index));
    if (seq_done === 1'b1) begin
      n_done = n_done + 1;
      if (step_tick === 1'b1) n_done_tick = n_done_tick + 1;
      if (busy === 1'b0) n_done_idle = n_done_idle + 1;
    end
    if (busy === 1'b1) n_busy = n_busy + 1;
    if (start_clock === 1'b1) begin
      if (!prev_sc) begin
        if (clock_done) n_viol = n_viol + 1;
        if (prev_busy) q_gap.push_back(low_len);
        high_len = 1;
      end else begin
        high_len = high_len + 1;
      end
    end else begin
      if (prev_sc) begin
        q_high.push_back(high_len);
        low_len = 1;
      end else begin
        low_len = low_len + 1;
      end
    end
    prev_sc   = (start_clock === 1'b1);
    prev_busy = (busy === 1'b1);
  end

  int s_tick, s_gap, s_done, s_done_tick, s_done_idle, s_busy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      failures = failures + 1;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic snap();
    s_tick = q_tick.size(); s_gap = q_gap.size(); s_done = n_done;
    s_done_tick = n_done_tick; s_done_idle = n_done_idle; s_busy = n_busy;
  endtask

  task automatic pulse_go(input logic [3:0] s);
    go = 1'b1; steps = s;
    cyc(1);
    go = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget, input bit rnd_pause);
    int k = 0;
    while (busy === 1'b1 && k < budget) begin
      if (rnd_pause) pause = ($urandom_range(0, 3) == 0);
      cyc(1);
      k = k + 1;
    end
    pause = 1'b0;
    chk({tag, "_ended"}, busy, 0);
    cyc(2);
  endtask

  // Expected outcome of a completed sequence of n intervals, from the rules.
  task automatic check_seq(input string tag, input int n);
    chk({tag, "_ticks"}, q_tick.size() - s_tick, n);
    for (int i = 0; i < n; i++) begin
      if (s_tick + i < q_tick.size()) chk({tag, "_idx"}, q_tick[s_tick + i], i);
    end
    chk({tag, "_done"}, n_done - s_done, 1);
    chk({tag, "_done_w_tick"}, n_done_tick - s_done_tick, 1);
    chk({tag, "_done_busy_low"}, n_done_idle - s_done_idle, 1);
    for (int i = s_gap; i < q_gap.size(); i++) chk({tag, "_gap_ge2"}, q_gap[i] >= 2, 1);
    chk({tag, "_no_err"}, timeout_err, 0);
  endtask

  initial begin
    int k;
    int bad;
    int tick_in_pause;
    int n;

    // Reset state
    cyc(2);
    chk("rst_start_clock", start_clock, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tick", step_tick, 0);
    chk("rst_done", seq_done, 0);
    chk("rst_index", step_index, 0);
    chk("rst_err", timeout_err, 0);
    rst = 1'b0;
    cyc(2);

    // Three intervals, with an ignored go part way through
    snap();
    pulse_go(4'd3);
    cyc(8);
    pulse_go(4'd1);
    wait_idle("seq3", 200, 1'b0);
    check_seq("seq3", 3);

    // Zero steps: seq_done next cycle, never busy
    snap();
    pulse_go(4'd0);
    chk("zero_done", seq_done, 1);
    chk("zero_busy", busy, 0);
    chk("zero_sc", start_clock, 0);
    cyc(1);
    chk("zero_done_once", seq_done, 0);
    cyc(2);
    chk("zero_busy_cnt", n_busy - s_busy, 0);

    // Pause during interval 0 for 10 cycles
    snap();
    pulse_go(4'd2);
    cyc(1);
    pause = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      if (q_tick.size() > s_tick && start_clock !== 1'b0) bad = bad + 1;
    end
    tick_in_pause = q_tick.size() - s_tick;
    pause = 1'b0;
    chk("pause_tick0", tick_in_pause, 1);
    chk("pause_sc_low", bad, 0);
    chk("pause_busy", busy, 1);
    wait_idle("pause", 200, 1'b0);
    check_seq("pause", 2);

    // Timer silent: watchdog expiry after exactly 20 cycles of start_clock
    tmr_en = 1'b0;
    snap();
    pulse_go(4'd1);
    wait_idle("wd", 100, 1'b0);
    chk("wd_high_len", (q_high.size() > 0) ? q_high[q_high.size() - 1] : -1, 20);
    chk("wd_err", timeout_err, 1);
    chk("wd_busy", busy, 0);
    chk("wd_no_done", n_done - s_done, 0);
    chk("wd_no_tick", q_tick.size() - s_tick, 0);
    tmr_en = 1'b1;
    pulse_go(4'd0);
    chk("wd_err_cleared", timeout_err, 0);
    cyc(2);

    // Abort in the cycle clock_done first rises, then restart while done is still high
    snap();
    pulse_go(4'd4);
    cyc(1);
    pulse_go(4'd1);
    k = 0;
    while (clock_done !== 1'b1 && k < 20) begin
      cyc(1);
      k = k + 1;
    end
    chk("abort_done_seen", clock_done, 1);
    abort = 1'b1;
    cyc(1);
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_sc", start_clock, 0);
    chk("abort_tick", step_tick, 0);
    chk("abort_done", seq_done, 0);
    chk("abort_index", step_index, 0);
    pulse_go(4'd2);
    wait_idle("abort", 200, 1'b0);
    check_seq("abort", 2);

    // Reset mid-RUN, then a clean restart
    pulse_go(4'd3);
    cyc(4);
    rst = 1'b1;
    cyc(1);
    chk("mid_rst_sc", start_clock, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_index", step_index, 0);
    chk("mid_rst_tick", step_tick, 0);
    chk("mid_rst_done", seq_done, 0);
    rst = 1'b0;
    cyc(2);
    snap();
    pulse_go(4'd2);
    wait_idle("post_rst", 200, 1'b0);
    check_seq("post_rst", 2);

    // Randomized sequences with random pause activity
    for (int r = 0; r < 8; r++) begin
      n = $urandom_range(1, 7);
      snap();
      pulse_go(4'(n));
      wait_idle("rand", 2000, 1'b1);
      check_seq("rand", n);
    end

    chk("no_sc_over_done", n_viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global bound so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "time limit");
  end

endmodule
